// File: rtl/weight_tile_fifo.sv
// Tile-granular weight FIFO between the off-chip weight port and the MAC array.
// Rows become visible only after their whole tile lands. Define WFIFO_ZERO_PAD_EN to zero-pad short tiles.
module weight_tile_fifo #(
    parameter int LANES       = 32,
    parameter int W_BITS      = 8,
    parameter int TILE_ROWS   = 32,
    parameter int DEPTH_TILES = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [LANES-1:0][W_BITS-1:0]         data_i,
    input  logic                                 sending_data_i,
    input  logic                                 tile_last_i,
    input  logic                                 read_en_i,
    output logic                                 request_data_o,
    output logic                                 valid_o,
    output logic [LANES-1:0][W_BITS-1:0]         data_o,
    output logic                                 tile_start_o,
    output logic                                 tile_end_o,
    output logic                                 fifo_full_o,
    output logic [$clog2(DEPTH_TILES+1)-1:0]     occupancy_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o
);

    localparam int ROWS  = DEPTH_TILES * TILE_ROWS;
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RC_W  = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam int OCC_W = $clog2(DEPTH_TILES + 1);
    localparam int AV_W  = $clog2(ROWS + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ROWS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [RC_W-1:0]  ROW_LAST = RC_W'(TILE_ROWS - 1);
    localparam logic [RC_W-1:0]  ROW_ONE  = RC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
`ifdef WFIFO_ZERO_PAD_EN
        PAD,
`endif
        RECV
    } state_t;

    typedef logic [LANES-1:0][W_BITS-1:0] row_t;

    row_t             mem [ROWS];
    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [RC_W-1:0]  row_cnt;
    logic [RC_W-1:0]  rd_row;
    logic [OCC_W-1:0] free_tiles;
    logic [AV_W-1:0]  rows_avail;
    logic [AV_W-1:0]  avail_nxt;
    logic             commit_p;
    logic             free_p;
    logic             accept;
    logic             start;
    logic             wr_en;
    logic             ovf_set;
    logic             pop;
    row_t             wr_data;

`ifndef WFIFO_ZERO_PAD_EN
    logic unused_last;
    assign unused_last = tile_last_i;
`endif

    always_comb begin
        accept  = 1'b0;
        ovf_set = 1'b0;
        wr_en   = 1'b0;
        wr_data = data_i;
        case (state)
            IDLE: ovf_set = sending_data_i;
            REQ: begin
                accept  = sending_data_i && (free_tiles != '0);
                ovf_set = sending_data_i && (free_tiles == '0);
            end
            RECV: accept = sending_data_i;
`ifdef WFIFO_ZERO_PAD_EN
            PAD: begin
                wr_en   = 1'b1;
                wr_data = '0;
                ovf_set = sending_data_i;
            end
`endif
            default: ovf_set = sending_data_i;
        endcase
        if (accept)
            wr_en = 1'b1;
    end

    assign start     = accept && (state == REQ);
    assign pop       = read_en_i && valid_o;
    assign avail_nxt = rows_avail - AV_W'(pop) + (commit_p ? AV_W'(TILE_ROWS) : '0);

    // Write side: tile framing FSM and write pointer
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            request_data_o <= 1'b0;
            row_cnt        <= '0;
            wr_ptr         <= '0;
            commit_p       <= 1'b0;
        end else begin
            commit_p <= 1'b0;
            if (wr_en)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            case (state)
                IDLE: begin
                    if (free_tiles != '0) begin
                        state          <= REQ;
                        request_data_o <= 1'b1;
                    end
                end
                REQ, RECV: begin
                    if (accept) begin
                        request_data_o <= 1'b0;
                        if (row_cnt == ROW_LAST) begin
                            state    <= IDLE;
                            row_cnt  <= '0;
                            commit_p <= 1'b1;
`ifdef WFIFO_ZERO_PAD_EN
                        end else if (tile_last_i) begin
                            state   <= PAD;
                            row_cnt <= row_cnt + ROW_ONE;
`endif
                        end else begin
                            state   <= RECV;
                            row_cnt <= row_cnt + ROW_ONE;
                        end
                    end
                end
`ifdef WFIFO_ZERO_PAD_EN
                PAD: begin
                    if (row_cnt == ROW_LAST) begin
                        state    <= IDLE;
                        row_cnt  <= '0;
                        commit_p <= 1'b1;
                    end else begin
                        row_cnt <= row_cnt + ROW_ONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; only the pointers decide what is live
    always_ff @(posedge clk_i) begin
        if (wr_en && rst_i)
            mem[wr_ptr] <= wr_data;
    end

    assign data_o = mem[rd_ptr];

    // Read side, slot accounting and sticky flags
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr      <= '0;
            rd_row      <= '0;
            rows_avail  <= '0;
            valid_o     <= 1'b0;
            free_p      <= 1'b0;
            occupancy_o <= '0;
            free_tiles  <= OCC_W'(DEPTH_TILES);
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            free_p <= pop && (rd_row == ROW_LAST);
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
                rd_row <= (rd_row == ROW_LAST) ? '0 : rd_row + ROW_ONE;
            end
            rows_avail  <= avail_nxt;
            valid_o     <= (avail_nxt != '0);
            occupancy_o <= occupancy_o + OCC_W'(commit_p) - OCC_W'(free_p);
            free_tiles  <= free_tiles - OCC_W'(start) + OCC_W'(free_p);
            overflow_o  <= overflow_o | ovf_set;
            underflow_o <= underflow_o | (read_en_i && !valid_o);
        end
    end

    assign fifo_full_o  = (free_tiles == '0);
    assign tile_start_o = valid_o && (rd_row == '0);
    assign tile_end_o   = valid_o && (rd_row == ROW_LAST);

endmodule
